// File: rtl/op_issue_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : op_issue_seq_pkg
//  Purpose  : Shared encodings, default sizes and FSM state type for the
//             op_issue_seq command issue sequencer.
//  Contents : OP_ADD / OP_SUB op-select encodings,
//             DEF_WIDTH / DEF_DEPTH default operand width and queue depth,
//             state_t issue FSM state type.
//  Revision : 1.0  initial release
// ============================================================================
package op_issue_seq_pkg;

    // Op-select encoding on cmd_op / in0
    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    // Default operand width and command queue depth
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    // Issue FSM: IDLE = queue empty, RUN = issuing, STALL = held by downstream
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

endpackage : op_issue_seq_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with one-extra-bit pointers distinguishing
//             full from empty. Read data is the head entry, taken straight
//             from storage; there is no write-to-read bypass.
//  Ports    : clk, rst        clock, asynchronous active-high reset
//             wr_en, wr_data  push request / data (ignored when full)
//             rd_en           pop request (ignored when empty)
//             rd_data         current head entry
//             full, empty     occupancy flags
//             count           number of stored entries (0..DEPTH)
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_wr;
    logic              w_rd;

    // Low bits address storage; the top bit flags a lap difference, so equal
    // low bits mean empty when the laps match and full when they differ.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign count = r_wr_ptr - r_rd_ptr;

    assign w_wr = wr_en & ~full;
    assign w_rd = rd_en & ~empty;

    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Pointers wrap naturally modulo 2*DEPTH, addresses modulo DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/op_issue_seq.sv
`default_nettype none
// ============================================================================
//  Module   : op_issue_seq
//  Purpose  : Queues add/subtract commands and issues them in order, one per
//             clock, to a downstream arithmetic stage that may stall.
//  Ports    : clk, rst            clock, asynchronous active-high reset
//             cmd_valid/cmd_ready command handshake (ready = queue not full)
//             cmd_op, cmd_a/b     op select (1 = add, 0 = sub) and operands
//             stall               downstream asks for no issue this cycle
//             in0, in1, in2       registered op select and operands issued
//             issue_valid         in0..in2 carry a new command this cycle
//             issue_cnt           commands issued since reset (wraps at 256)
//             busy                FSM in RUN or STALL
//  Revision : 1.0  initial release
// ============================================================================
module op_issue_seq
    import op_issue_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             stall,
    output logic             in0,
    output logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] in2,
    output logic             issue_valid,
    output logic [7:0]       issue_cnt,
    output logic             busy
);

    localparam int DATA_W = 1 + 2 * WIDTH;
    localparam int AW     = $clog2(DEPTH);

    typedef logic [AW:0] occ_t;

    logic              w_full;
    logic              w_empty;
    occ_t              w_count;
    occ_t              w_count_next;
    logic [DATA_W-1:0] w_head;
    logic              w_push;
    logic              w_pop;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_in0;
    logic [WIDTH-1:0]  r_in1;
    logic [WIDTH-1:0]  r_in2;
    logic              r_issue_valid;
    logic [7:0]        r_issue_cnt;

    // Ready depends only on occupancy, never on stall or the same-cycle pop
    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & cmd_ready;
    assign w_pop     = ~w_empty & ~stall;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data ({cmd_op, cmd_a, cmd_b}),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next state follows the occupancy the queue will have after this edge
    always_comb begin
        w_count_next = w_count + occ_t'(w_push) - occ_t'(w_pop);
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_count_next != '0) w_state_next = stall ? ST_STALL : ST_RUN;
            end
            ST_RUN: begin
                if (stall && !w_empty)       w_state_next = ST_STALL;
                else if (w_count_next == '0) w_state_next = ST_IDLE;
            end
            ST_STALL: begin
                if (!stall) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Issue registers: load the head on a pop, otherwise hold last values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in0         <= 1'b0;
            r_in1         <= '0;
            r_in2         <= '0;
            r_issue_valid <= 1'b0;
            r_issue_cnt   <= 8'd0;
        end else begin
            r_issue_valid <= w_pop;
            if (w_pop) begin
                {r_in0, r_in1, r_in2} <= w_head;
                r_issue_cnt           <= r_issue_cnt + 8'd1;
            end
        end
    end

    assign in0         = r_in0;
    assign in1         = r_in1;
    assign in2         = r_in2;
    assign issue_valid = r_issue_valid;
    assign issue_cnt   = r_issue_cnt;
    assign busy        = (r_state != ST_IDLE);

endmodule : op_issue_seq
`default_nettype wire

// File: tb/tb_op_issue_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_op_issue_seq
//  Purpose  : Directed self-checking bench for op_issue_seq (WIDTH=4,
//             DEPTH=4) with a small registered add/sub stage on the outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_op_issue_seq;
    import op_issue_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       stall;
    logic       in0;
    logic [3:0] in1;
    logic [3:0] in2;
    logic       issue_valid;
    logic [7:0] issue_cnt;
    logic       busy;

    logic [3:0] r_result;

    int total = 0;
    int bad   = 0;

    op_issue_seq #(.WIDTH(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .stall       (stall),
        .in0         (in0),
        .in1         (in1),
        .in2         (in2),
        .issue_valid (issue_valid),
        .issue_cnt   (issue_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Downstream arithmetic stage fed by the issue registers
    always_ff @(posedge clk) begin
        if (issue_valid) r_result <= (in0 == OP_ADD) ? (in1 + in2) : (in1 - in2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic op, input logic [3:0] a, input logic [3:0] b);
        cmd_valid = v;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    initial begin
        int pulses;
        logic [11:0] exp_pop;
        logic [3:0]  exp_a;

        rst = 1'b1;
        stall = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        tick();

        // Reset state
        chk("rst_outputs", {in0, in1, in2, issue_valid, issue_cnt, busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", cmd_ready, 1);

        // add(3,4) into empty queue: no bypass, issue one cycle later, then hold
        drive(1'b1, OP_ADD, 4'd3, 4'd4);
        tick();
        chk("add_no_bypass", issue_valid, 0);
        chk("add_busy", busy, 1);
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        chk("add_issue", {issue_valid, in0, in1, in2}, {1'b1, 1'b1, 4'd3, 4'd4});
        chk("add_cnt", issue_cnt, 1);
        tick();
        chk("add_hold", {issue_valid, in0, in1, in2}, {1'b0, 1'b1, 4'd3, 4'd4});
        chk("add_idle", busy, 0);

        // Stall high: fill the queue, 5th command held off
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'(i), 4'(i + 1), 4'(i + 5));
            #1;
            chk("fill_ready", cmd_ready, 1);
            tick();
        end
        chk("full_ready_low", cmd_ready, 0);
        drive(1'b1, OP_ADD, 4'd9, 4'd10);
        tick();
        chk("full_held", {cmd_ready, issue_valid, issue_cnt}, {1'b0, 1'b0, 8'd1});
        chk("full_busy", busy, 1);
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_issue", {issue_valid, in0, in1, in2},
                {1'b1, 1'(i), 4'(i + 1), 4'(i + 5)});
            chk("drain_cnt", issue_cnt, 32'(i + 2));
            chk("drain_ready", cmd_ready, 1);
        end
        drive(1'b1, OP_ADD, 4'd9, 4'd10);
        tick();
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        chk("fifth_issue", {issue_valid, in0, in1, in2, issue_cnt},
            {1'b1, 1'b1, 4'd9, 4'd10, 8'd6});
        tick();
        chk("fifth_after", issue_valid, 0);

        // Stall toggles each cycle during a 4-entry burst (pops at k=2,4,6,8)
        exp_pop = 12'b0001_0101_0100;
        pulses  = 0;
        exp_a   = 4'd8;
        for (int k = 0; k < 12; k++) begin
            stall = k[0];
            if (k < 4) drive(1'b1, OP_SUB, 4'(8 + k), 4'(k));
            else       drive(1'b0, 1'b0, 4'd0, 4'd0);
            tick();
            chk("tog_valid", issue_valid, exp_pop[k]);
            if (issue_valid) begin
                pulses++;
                chk("tog_order", {in0, in1, in2}, {OP_SUB, exp_a, exp_a - 4'd8});
                exp_a = exp_a + 4'd1;
            end
        end
        stall = 1'b0;
        chk("tog_pulses", pulses, 4);
        chk("tog_cnt", issue_cnt, 10);

        // Reset with 3 entries queued discards them
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_ADD, 4'(i + 1), 4'(i + 2));
            tick();
        end
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {in0, in1, in2, issue_valid, issue_cnt, busy}, 32'd0);
        tick();
        rst = 1'b0;
        stall = 1'b0;
        #1;
        chk("mid_rst_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_no_issue", {issue_valid, issue_cnt, busy}, 32'd0);
        end

        // 300 back-to-back commands; count wraps to 44
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'(i), 4'(i), ~4'(i));
            tick();
            if (i > 0)
                chk("b2b_issue", {issue_valid, in0, in1, in2},
                    {1'b1, 1'(i - 1), 4'(i - 1), ~4'(i - 1)});
        end
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        chk("b2b_last", {issue_valid, in0, in1, in2}, {1'b1, 1'b1, 4'(299), ~4'(299)});
        chk("b2b_cnt_wrap", issue_cnt, 44);
        tick();
        chk("b2b_done", issue_valid, 0);

        // sub(2,9) through the downstream stage -> 9
        drive(1'b1, OP_SUB, 4'd2, 4'd9);
        tick();
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        chk("sub_issue", {issue_valid, in0, in1, in2}, {1'b1, OP_SUB, 4'd2, 4'd9});
        tick();
        chk("sub_result", r_result, 9);
        chk("sub_cnt", issue_cnt, 45);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_op_issue_seq
`default_nettype wire
